// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - multi-channel ADC sample packer with TLP grouping, drop accounting and start-pulse train
module adc_frame_packer #(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 12,
  parameter int DATA_W      = 64,
  parameter int TLP_BEATS   = 15,
  parameter int PULSE_SLOTS = 32
) (
  input  logic                       InputClock,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] ADC_in,
  input  logic [12:0]                FrameLength,
  input  logic [6:0]                 PulseWidth,
  input  logic [PULSE_SLOTS-1:0]     PulseMask,
  input  logic [2:0]                 ChannelSel,
  input  logic                       AutoChannel,
  input  logic                       Mode12,
  input  logic                       TestMode,
  input  logic [15:0]                BufferLengthTLPs,
  input  logic                       FifoAlmostFull,
  output logic [DATA_W-1:0]          TLPData,
  output logic [39:0]                TLPHeader,
  output logic                       DataWriteEnable,
  output logic                       HeaderWriteEnable,
  output logic                       StartPulse,
  output logic                       FrameSync,
  output logic                       Overflow,
  output logic [15:0]                DropCount
);

  logic                   running;
  logic [13:0]            wordIdx, nxtWordIdx;
  logic [3:0]             slotIdx, nxtSlotIdx, lastSlot;
  logic [6:0]             pulseCnt, nxtPulseCnt, slotWidth;
  logic [5:0]             pulseSlot, nxtPulseSlot;
  logic [2:0]             chanCnt, chan;
  logic [7:0]             testCnt;
  logic [55:0]            shiftBuf, nxtShiftBuf;
  logic [DATA_W-1:0]      packedWord;
  logic                   wordReady;
  logic [4:0]             beatCnt;
  logic [15:0]            tlpCnt, bufCnt;
  logic [12:0]            shFrameLength;
  logic [6:0]             shPulseWidth;
  logic [PULSE_SLOTS-1:0] shPulseMask;
  logic [2:0]             shChannelSel;
  logic                   shAutoChannel, shMode12;
  logic [15:0]            shBufferLength;
  logic [SAMPLE_W-1:0]    adcSample, sample;
  logic                   inFrame, frameStart, lastCapture, nxtInFrame, pulseLow;
  logic [31:0]            nxtMask;

  // Frame position, channel selection and word assembly for the current cycle.
  always_comb begin
    lastSlot    = shMode12 ? 4'd4 : 4'd7;
    inFrame     = running && (wordIdx <= {1'b0, shFrameLength});
    frameStart  = !running || (!inFrame && slotIdx == lastSlot);
    lastCapture = inFrame && (slotIdx == lastSlot);
    slotWidth   = (shPulseWidth == 7'd0) ? 7'd1 : shPulseWidth;
    if (shAutoChannel)
      chan = chanCnt;
    else if (int'(shChannelSel) >= NUM_CH)
      chan = 3'd0;
    else
      chan = shChannelSel;
    adcSample = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(chan) == c) adcSample = ADC_in[c*SAMPLE_W +: SAMPLE_W];
    sample = TestMode ? {{(SAMPLE_W-8){1'b0}}, testCnt} : adcSample;
    if (shMode12) begin
      nxtShiftBuf = {shiftBuf[43:0], sample[11:0]};
      packedWord  = {shiftBuf[47:0], sample[11:0], 4'b0000};
    end else begin
      nxtShiftBuf = {shiftBuf[47:0], sample[7:0]};
      packedWord  = {shiftBuf[55:0], sample[7:0]};
    end
  end

  // Next frame position; the start pulse is registered from the look-ahead position.
  always_comb begin
    nxtWordIdx   = wordIdx;
    nxtSlotIdx   = slotIdx;
    nxtPulseCnt  = pulseCnt;
    nxtPulseSlot = pulseSlot;
    if (frameStart) begin
      nxtWordIdx   = '0;
      nxtSlotIdx   = '0;
      nxtPulseCnt  = '0;
      nxtPulseSlot = '0;
    end else begin
      if (slotIdx == lastSlot) begin
        nxtSlotIdx = '0;
        nxtWordIdx = wordIdx + 14'd1;
      end else begin
        nxtSlotIdx = slotIdx + 4'd1;
      end
      if (pulseCnt >= slotWidth - 7'd1) begin
        nxtPulseCnt = '0;
        if (int'(pulseSlot) < PULSE_SLOTS) nxtPulseSlot = pulseSlot + 6'd1;
      end else begin
        nxtPulseCnt = pulseCnt + 7'd1;
      end
    end
    nxtMask    = 32'(frameStart ? PulseMask : shPulseMask);
    nxtInFrame = frameStart || (nxtWordIdx <= {1'b0, shFrameLength});
    pulseLow   = nxtInFrame && (int'(nxtPulseSlot) < PULSE_SLOTS) && nxtMask[nxtPulseSlot[4:0]];
  end

  always_ff @(posedge InputClock) begin
    if (rst) begin
      running        <= 1'b0;
      wordIdx        <= '0;
      slotIdx        <= '0;
      pulseCnt       <= '0;
      pulseSlot      <= '0;
      chanCnt        <= '0;
      testCnt        <= '0;
      shiftBuf       <= '0;
      wordReady      <= 1'b0;
      beatCnt        <= '0;
      tlpCnt         <= '0;
      bufCnt         <= '0;
      TLPData        <= '0;
      TLPHeader      <= '0;
      StartPulse     <= 1'b1;
      FrameSync      <= 1'b0;
      Overflow       <= 1'b0;
      DropCount      <= '0;
      shFrameLength  <= FrameLength;
      shPulseWidth   <= PulseWidth;
      shPulseMask    <= PulseMask;
      shChannelSel   <= ChannelSel;
      shAutoChannel  <= AutoChannel;
      shMode12       <= Mode12;
      shBufferLength <= BufferLengthTLPs;
    end else begin
      running    <= 1'b1;
      wordIdx    <= nxtWordIdx;
      slotIdx    <= nxtSlotIdx;
      pulseCnt   <= nxtPulseCnt;
      pulseSlot  <= nxtPulseSlot;
      testCnt    <= testCnt + 8'd1;
      StartPulse <= !pulseLow;
      FrameSync  <= (nxtWordIdx == 14'd0);
      if (frameStart) begin
        chanCnt        <= '0;
        shFrameLength  <= FrameLength;
        shPulseWidth   <= PulseWidth;
        shPulseMask    <= PulseMask;
        shChannelSel   <= ChannelSel;
        shAutoChannel  <= AutoChannel;
        shMode12       <= Mode12;
        shBufferLength <= BufferLengthTLPs;
      end else if (inFrame) begin
        shiftBuf <= nxtShiftBuf;
        chanCnt  <= (int'(chanCnt) >= NUM_CH-1) ? 3'd0 : chanCnt + 3'd1;
      end
      // Header is staged with the word; counters only move in emission cycles, so these are pre-increment values.
      wordReady <= lastCapture;
      if (lastCapture) begin
        TLPData   <= packedWord;
        TLPHeader <= {bufCnt, tlpCnt, shChannelSel[0], shMode12, Overflow, 5'b11111};
      end
      if (wordReady) begin
        if (FifoAlmostFull) begin
          Overflow <= 1'b1;
          if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
        end else if (int'(beatCnt) >= TLP_BEATS-1) begin
          beatCnt <= '0;
          if (tlpCnt >= shBufferLength) begin
            tlpCnt <= '0;
            bufCnt <= bufCnt + 16'd1;
          end else begin
            tlpCnt <= tlpCnt + 16'd1;
          end
        end else begin
          beatCnt <= beatCnt + 5'd1;
        end
      end
    end
  end

  assign DataWriteEnable   = wordReady && !FifoAlmostFull;
  assign HeaderWriteEnable = DataWriteEnable && (int'(beatCnt) == TLP_BEATS-1);

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - table, directed and randomized checks of adc_frame_packer against a frame-level model
module tb_adc_frame_packer;
  localparam int NUM_CH = 2, SAMPLE_W = 12, TLP_BEATS = 15, PULSE_SLOTS = 32, MAXC = 20000;

  logic                       InputClock = 1'b0;
  logic                       rst;
  logic [NUM_CH*SAMPLE_W-1:0] ADC_in;
  logic [12:0]                FrameLength;
  logic [6:0]                 PulseWidth;
  logic [PULSE_SLOTS-1:0]     PulseMask;
  logic [2:0]                 ChannelSel;
  logic                       AutoChannel, Mode12, TestMode, FifoAlmostFull;
  logic [15:0]                BufferLengthTLPs;
  logic [63:0]                TLPData;
  logic [39:0]                TLPHeader;
  logic                       DataWriteEnable, HeaderWriteEnable, StartPulse, FrameSync, Overflow;
  logic [15:0]                DropCount;

  always #5 InputClock = ~InputClock;

  adc_frame_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DATA_W(64), .TLP_BEATS(TLP_BEATS),
                     .PULSE_SLOTS(PULSE_SLOTS)) dut (
    .InputClock(InputClock), .rst(rst), .ADC_in(ADC_in), .FrameLength(FrameLength),
    .PulseWidth(PulseWidth), .PulseMask(PulseMask), .ChannelSel(ChannelSel),
    .AutoChannel(AutoChannel), .Mode12(Mode12), .TestMode(TestMode),
    .BufferLengthTLPs(BufferLengthTLPs), .FifoAlmostFull(FifoAlmostFull),
    .TLPData(TLPData), .TLPHeader(TLPHeader), .DataWriteEnable(DataWriteEnable),
    .HeaderWriteEnable(HeaderWriteEnable), .StartPulse(StartPulse), .FrameSync(FrameSync),
    .Overflow(Overflow), .DropCount(DropCount));

  int tests = 0, fails = 0;
  logic        sDwe, sHwe, sSp, sFs, sOvf;
  logic [63:0] sData;
  logic [39:0] sHdr;
  logic [15:0] sDrop;

  typedef struct { int fl; int pw; logic [31:0] mask; int chsel; bit autoCh; bit m12; int bl; } cfg_t;
  cfg_t        cfg;
  int          cyc, fs, mBeat, mTlp, mBuf, mDrop;
  bit          mOvf;
  logic [11:0] hist [MAXC];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cfg_t currentCfg();
    cfg_t c;
    c.fl = int'(FrameLength); c.pw = int'(PulseWidth); c.mask = PulseMask;
    c.chsel = int'(ChannelSel); c.autoCh = AutoChannel; c.m12 = Mode12; c.bl = int'(BufferLengthTLPs);
    return c;
  endfunction

  // Frame-level reference: cycle c of a frame captures a sample while c < (FL+1)*P, word n appears at c = (n+1)*P.
  task automatic modelStep();
    int p, flen, c, ch, n, k, w;
    logic [63:0] word;
    bit expDwe, expHwe, expSp, expFs;
    expDwe = 0; expHwe = 0; expSp = 1; expFs = 0;
    check("Overflow", sOvf, mOvf);
    check("DropCount", sDrop, mDrop);
    if (cyc == 0) begin
      check("ResetTLPData", sData, 0);
      check("ResetTLPHeader", sHdr, 0);
      cfg = currentCfg();
      fs = 1;
    end else begin
      p = cfg.m12 ? 5 : 8;
      flen = (cfg.fl + 1) * p;
      c = cyc - fs;
      if (c < flen) begin
        ch = cfg.autoCh ? (c % NUM_CH) : ((cfg.chsel >= NUM_CH) ? 0 : cfg.chsel);
        hist[cyc % MAXC] = TestMode ? 12'(cyc % 256) : ADC_in[ch*SAMPLE_W +: 12];
        w = (cfg.pw == 0) ? 1 : cfg.pw;
        k = c / w;
        expSp = !(k < PULSE_SLOTS && cfg.mask[k]);
      end
      expFs = (c < p);
      if (c >= p && c <= flen && (c % p) == 0) begin
        n = c / p - 1;
        word = 0;
        for (int j = 0; j < p; j++) begin
          if (cfg.m12) word = (word << 12) | 64'(hist[(fs + n*p + j) % MAXC]);
          else         word = (word << 8)  | 64'(hist[(fs + n*p + j) % MAXC][7:0]);
        end
        if (cfg.m12) word = word << 4;
        expDwe = !FifoAlmostFull;
        expHwe = expDwe && (mBeat == TLP_BEATS-1);
        if (expDwe) check("TLPData", sData, word);
        if (expHwe) check("TLPHeader", sHdr, {16'(mBuf), 16'(mTlp), 1'(cfg.chsel), cfg.m12, mOvf, 5'h1F});
        if (FifoAlmostFull) begin
          mOvf = 1;
          if (mDrop < 65535) mDrop++;
        end else if (mBeat == TLP_BEATS-1) begin
          mBeat = 0;
          if (mTlp >= cfg.bl) begin mTlp = 0; mBuf = (mBuf + 1) % 65536; end
          else mTlp++;
        end else begin
          mBeat++;
        end
      end
      if (c == flen + p - 1) begin
        fs = cyc + 1;
        cfg = currentCfg();
      end
    end
    check("DataWriteEnable", sDwe, expDwe);
    check("HeaderWriteEnable", sHwe, expHwe);
    check("StartPulse", sSp, expSp);
    check("FrameSync", sFs, expFs);
    cyc++;
  endtask

  task automatic tick();
    @(negedge InputClock);
    sDwe = DataWriteEnable; sHwe = HeaderWriteEnable; sSp = StartPulse; sFs = FrameSync;
    sOvf = Overflow; sData = TLPData; sHdr = TLPHeader; sDrop = DropCount;
    modelStep();
    @(posedge InputClock); #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(posedge InputClock); #1;
    @(posedge InputClock); #1;
    rst = 1'b0;
    cyc = 0; mBeat = 0; mTlp = 0; mBuf = 0; mDrop = 0; mOvf = 0;
  endtask

  typedef struct { bit m12; bit autoCh; logic [2:0] chsel; bit tm; logic [11:0] ch0, ch1; logic [63:0] expWord; int period; } vec_t;
  vec_t vecs[7];

  initial begin
    int first, second, nh, words, hdrT;
    logic [63:0] firstWord;
    logic [7:0]  pat;
    logic [39:0] hdrExp[4];
    vecs[0] = '{1'b0, 1'b0, 3'd1, 1'b0, 12'h03C, 12'h0A5, 64'hA5A5A5A5A5A5A5A5, 8};
    vecs[1] = '{1'b1, 1'b1, 3'd0, 1'b0, 12'hABC, 12'h123, 64'hABC123ABC123ABC0, 5};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 1'b0, 12'h012, 12'h034, 64'h1234123412341234, 8};
    vecs[3] = '{1'b1, 1'b0, 3'd6, 1'b0, 12'hFFF, 12'h000, 64'hFFFFFFFFFFFFFFF0, 5};
    vecs[4] = '{1'b0, 1'b0, 3'd0, 1'b0, 12'h9C3, 12'h111, 64'hC3C3C3C3C3C3C3C3, 8};
    vecs[5] = '{1'b1, 1'b0, 3'd1, 1'b0, 12'h000, 12'h801, 64'h8018018018018010, 5};
    vecs[6] = '{1'b0, 1'b0, 3'd1, 1'b1, 12'h000, 12'h000, 64'h0102030405060708, 8};
    hdrExp = '{40'h000000001F, 40'h000000011F, 40'h000100001F, 40'h000100011F};

    rst = 1'b1; ADC_in = '0; FrameLength = 13'd3; PulseWidth = 7'd1; PulseMask = '0;
    ChannelSel = 3'd0; AutoChannel = 1'b0; Mode12 = 1'b0; TestMode = 1'b0;
    BufferLengthTLPs = 16'd0; FifoAlmostFull = 1'b0;
    @(posedge InputClock); #1;

    foreach (vecs[i]) begin
      Mode12 = vecs[i].m12; AutoChannel = vecs[i].autoCh; ChannelSel = vecs[i].chsel;
      TestMode = vecs[i].tm; ADC_in = {vecs[i].ch1, vecs[i].ch0}; FrameLength = 13'd3;
      resetDut();
      first = -1; second = -1; firstWord = '0;
      for (int t = 0; t < 40 && second < 0; t++) begin
        tick();
        if (sDwe) begin
          if (first < 0) begin first = t; firstWord = sData; end
          else second = t;
        end
      end
      check("vecWord", firstWord, vecs[i].expWord);
      check("vecLatency", 64'(first), 64'(vecs[i].period + 1));
      check("vecPeriod", 64'(second - first), 64'(vecs[i].period));
    end

    // Start-pulse slots: width 2 and width 0 (treated as 1) with mask 0b101
    TestMode = 1'b0; Mode12 = 1'b0; AutoChannel = 1'b0; PulseMask = 32'h0000_0005;
    for (int v = 0; v < 2; v++) begin
      PulseWidth = (v == 0) ? 7'd2 : 7'd0;
      resetDut();
      tick();
      pat = '0;
      for (int t = 0; t < 8; t++) begin tick(); pat = {pat[6:0], sSp}; end
      check("pulsePattern", pat, (v == 0) ? 8'h33 : 8'h5F);
    end

    // TLP headers every 15 words with a two-TLP buffer
    PulseMask = '0; PulseWidth = 7'd1; FrameLength = 13'd63; BufferLengthTLPs = 16'd1; ChannelSel = 3'd0;
    resetDut();
    nh = 0; words = 0;
    for (int t = 0; t < 700 && nh < 4; t++) begin
      tick();
      if (sDwe) words++;
      if (sHwe) begin
        check("hdrWordIndex", 64'(words), 64'(15 * (nh + 1)));
        check("hdrValue", sHdr, hdrExp[nh]);
        nh++;
      end
    end
    check("hdrCount", 64'(nh), 64'd4);

    // Three dropped words delay the first header by three word periods
    BufferLengthTLPs = 16'd0;
    resetDut();
    hdrT = -1;
    for (int t = 0; t < 400 && hdrT < 0; t++) begin
      FifoAlmostFull = (t >= 41 && t < 65);
      tick();
      if (sHwe) begin hdrT = t; check("dropHdrValue", sHdr, 40'h000000003F); end
    end
    FifoAlmostFull = 1'b0;
    check("dropHdrTime", 64'(hdrT), 64'd145);
    check("dropCount3", sDrop, 16'd3);
    check("dropOverflow", sOvf, 1'b1);

    // Mid-frame config change, drops, then reset in the middle of a frame
    FrameLength = 13'd3; Mode12 = 1'b0; PulseMask = 32'h0000_00F0; PulseWidth = 7'd3;
    resetDut();
    words = 0;
    for (int t = 0; t < 41; t++) begin
      if (t == 5) begin FrameLength = 13'd1; Mode12 = 1'b1; PulseMask = 32'h1; end
      tick();
      if (sDwe) words++;
    end
    check("midFrameWords", 64'(words), 64'd4);
    for (int t = 0; t < 12; t++) begin FifoAlmostFull = 1'b1; tick(); end
    FifoAlmostFull = 1'b0;
    resetDut();
    for (int t = 0; t < 30; t++) tick();

    // Randomized stimulus with random mid-frame config changes and back-pressure
    resetDut();
    for (int t = 0; t < 4000; t++) begin
      ADC_in = NUM_CH*SAMPLE_W'($urandom);
      FifoAlmostFull = ($urandom_range(0, 4) == 0);
      if ((t % 300) == 0) TestMode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) begin
        FrameLength = 13'($urandom_range(0, 4)); PulseWidth = 7'($urandom_range(0, 3));
        PulseMask = $urandom; ChannelSel = 3'($urandom_range(0, 7));
        AutoChannel = $urandom_range(0, 1) == 1; Mode12 = $urandom_range(0, 1) == 1;
        BufferLengthTLPs = 16'($urandom_range(0, 3));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
Parametrised successor to the single-purpose 8/12-bit ADC packer. Samples NUM_CH ADC channels on the ADC clock and packs them into DATA_W-bit FIFO words, in 8-bit or 12-bit mode selected at run time. Groups words into TLPs with a header word per TLP and drives the masked start-pulse train for each frame. Adds FIFO back-pressure handling: words are dropped while the FIFO is almost full, with counted drops and a sticky overflow flag.

Parameters:
NUM_CH, 2, number of ADC channels (1..8)
SAMPLE_W, 12, ADC sample width (>=12)
DATA_W, 64, output word width (fixed 64 in this generation)
TLP_BEATS, 15, data words per TLP (2..16)
PULSE_SLOTS, 32, number of start-pulse mask slots (1..32)

Ports:
InputClock  in  1  ADC clock; sole clock
rst  in  1  synchronous active-high reset
ADC_in  in  NUM_CH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W]
FrameLength  in  13  last word index of a frame (frame = FrameLength+1 words)
PulseWidth  in  7  start-pulse slot width in cycles; 0 is treated as 1
PulseMask  in  PULSE_SLOTS  1 = pulse active in slot k
ChannelSel  in  3  fixed channel when AutoChannel=0; values >=NUM_CH map to 0
AutoChannel  in  1  round-robin channel per sample
Mode12  in  1  0: 8 samples x 8 bit; 1: 5 samples x 12 bit + 4'b0
TestMode  in  1  replace samples with an 8-bit free-running counter
BufferLengthTLPs  in  16  last TLP index of a buffer
FifoAlmostFull  in  1  downstream back-pressure
TLPData  out  64  packed word
TLPHeader  out  40  header word
DataWriteEnable  out  1  one-cycle strobe, TLPData valid
HeaderWriteEnable  out  1  one-cycle strobe, TLPHeader valid
StartPulse  out  1  active-low optical start pulse
FrameSync  out  1  high during the first word period of each frame
Overflow  out  1  sticky drop flag
DropCount  out  16  saturating count of dropped words

Behaviour:
- Reset: all counters 0, StartPulse=1, FrameSync=0, strobes 0, TLPData=0, TLPHeader=0, Overflow=0, DropCount=0. Shadow config is loaded from the inputs.
- Shadow config (FrameLength, PulseWidth, PulseMask, ChannelSel, AutoChannel, Mode12, BufferLengthTLPs) is latched at reset and at each frame start only. Mid-frame input changes take effect at the next frame.
- Words per frame:
  - P = 8 samples per word (Mode12=0) or 5 samples per word (Mode12=1).
  - One sample is captured per cycle into slot s = 0..P-1.
  - Slot 0 is at the MSB end. 8-bit mode uses sample[7:0]. 12-bit mode uses sample[11:0], followed by 4'b0.
- Channel select:
  - AutoChannel=1: the channel is the channel counter value. The counter increments every sample, wraps at NUM_CH-1, and resets at frame start.
  - AutoChannel=0: the channel is ChannelSel.
- TestMode sample: {counter8} zero-extended. The counter increments every cycle and resets on rst only.
- Emission:
  - The cycle after slot P-1 is captured, the word is emitted: TLPData updates and DataWriteEnable=1 for exactly one cycle, unless dropped.
  - Capture continues without gaps, so the write latency is 1 cycle after the last sample.
- Frame sequence:
  - Words 0..FrameLength are emitted.
  - One gap word period (P cycles) follows with samples discarded and no strobes.
  - The next frame then starts: counters reset and shadow config reloads.
- TLP grouping:
  - A beat counter counts emitted words 0..TLP_BEATS-1.
  - On the word that takes the counter from TLP_BEATS-1 to 0, HeaderWriteEnable=1 in the same cycle as DataWriteEnable.
  - TLPHeader = {BufferCounter, TLPCounter, ChannelSel[0], Mode12, Overflow, 5'b11111}, using pre-increment counter values.
  - TLPCounter then increments. When it was >=BufferLengthTLPs it wraps to 0 and BufferCounter increments, wrapping at 16 bits.
  - The beat counter does not reset at frame boundaries.
- Drop:
  - If FifoAlmostFull=1 in the emission cycle, no strobes are asserted.
  - The beat, TLP and buffer counters hold.
  - Overflow is set (cleared only by rst). DropCount increments and saturates at 16'hFFFF.
  - Frame word counting still advances, so frame timing is unaffected.
- Start pulse:
  - From frame start, slot k spans PulseWidth cycles.
  - StartPulse=0 during slot k iff PulseMask[k] is 1.
  - StartPulse=1 for k>=PULSE_SLOTS and during the gap.
- FrameSync is registered: high during frame cycles 0..P-1, low otherwise.
- rst mid-frame: immediate return to reset state; the next frame starts at the cycle after rst deasserts.

Test Plan:
1. NUM_CH=2, Mode12=0, AutoChannel=0, ChannelSel=1, ADC ch1 ramps 0,1,2..., FrameLength=3 -> 4 words 0x0001020304050607, 0x08090A0B0C0D0E0F, ...; DataWriteEnable every 8 cycles; 8-cycle gap; then words restart.
2. Mode12=1, AutoChannel=1, ch0=0xABC, ch1=0x123 constant -> word 0xABC123ABC123ABC0, strobe every 5 cycles.
3. 60 emitted words, BufferLengthTLPs=1, TLP_BEATS=15 -> HeaderWriteEnable on words 15/30/45/60; headers {0,0},{0,1},{1,0},{1,1} in BufferCounter/TLPCounter fields; low byte 0x1F/0x3F per Mode12/Overflow bits.
4. FifoAlmostFull high for 3 emission slots -> 3 missing strobes, DropCount=3, Overflow=1 in subsequent headers; next header delayed by exactly 3 word periods; frame length is unchanged.
5. PulseWidth=2, PulseMask=32'h0000_0005 -> StartPulse low for frame cycles 0-1 and 4-5, high elsewhere; PulseWidth=0 -> behaves as width 1.
6. Change FrameLength and Mode12 mid-frame, then assert rst mid-frame -> changes apply only at the next frame start; after rst all outputs return to reset values, DropCount=0, and StartPulse=1.
